cc_collision_controller: RTL and testbench
==========================================

Name: cc_collision_controller

Overview:
- Consumes the merged row and the active-low lost flag produced by the player/obstacle comparator.
- Runs the round-level game flow: start, play, hit recovery with blink, and game over.
- Drives the display row, a freeze line that halts the player/obstacle shift registers, and the lives count.
- Sits between the comparator and the display/scroll logic. All outputs are registered.

Parameters:
- DATAWIDTH, 8, width of row buses.
- LIVES, 3, lives loaded at game start. Legal range 1..(2^LIVESWIDTH - 1).
- LIVESWIDTH, 2, width of lives counter/output.
- HIT_TICKS, 4, frame ticks spent in HIT state. Minimum 1.

Ports:
- CC_COLLISION_CONTROLLER_CLOCK_50  input  1  system clock, single clock domain.
- CC_COLLISION_CONTROLLER_RESET_InLow  input  1  asynchronous, active-low reset.
- CC_COLLISION_CONTROLLER_Start_InLow  input  1  start button level, active low, already synchronised.
- CC_COLLISION_CONTROLLER_Tick_InHigh  input  1  one-cycle frame tick pulse.
- CC_COLLISION_CONTROLLER_Data_InBus  input  DATAWIDTH  merged player|obstacle row from comparator.
- CC_COLLISION_CONTROLLER_Lost_InLow  input  1  collision flag from comparator, 0 = collision.
- CC_COLLISION_CONTROLLER_Data_OutBus  output  DATAWIDTH  row to display.
- CC_COLLISION_CONTROLLER_Freeze_OutHigh  output  1  1 = hold scroll/player shifters.
- CC_COLLISION_CONTROLLER_Lives_OutBus  output  LIVESWIDTH  remaining lives.
- CC_COLLISION_CONTROLLER_Hit_OutHigh  output  1  one-cycle pulse per accepted collision.
- CC_COLLISION_CONTROLLER_GameOver_OutHigh  output  1  1 while in OVER.

Behaviour:
Reset (asynchronous assert, synchronous release):
- State = IDLE, Lives = LIVES, Data_OutBus = 0, Freeze = 1, Hit = 0, GameOver = 0.
- Tick counter = 0, blink phase = 0.
- Start edge register = 1, so a button held low through reset is not seen as a press.
- Reset mid-operation aborts immediately to these values, with no dependence on the clock.

Start press:
- Defined as a falling edge: previous registered Start = 1 and current Start = 0.
- Exactly one press per edge. A held-low button does not repeat.

FSM states: IDLE, PLAY, HIT, OVER. All transitions and outputs update on the rising clock edge.

IDLE:
- Freeze = 1, Data_OutBus = 0, GameOver = 0.
- Start press -> PLAY; Lives reloaded to LIVES.

PLAY:
- Freeze = 0.
- Data_OutBus <= Data_InBus every cycle, giving 1-cycle latency.
- A collision is accepted only when Tick = 1 and Lost_InLow = 0 in the same cycle. Lost_InLow = 0 without Tick is ignored, which masks mid-frame glitches.
- On an accepted collision at cycle N, at N+1:
  - Hit = 1 for exactly one cycle, Lives = Lives - 1, Freeze = 1.
  - If the pre-decrement Lives = 1 -> OVER (Lives = 0).
  - Otherwise -> HIT, with tick counter = 0 and blink phase = 0.
- Start press in PLAY is ignored. A collision in the same cycle as a start press: collision wins.

HIT:
- Freeze = 1. Lost_InLow and Start are ignored.
- Data_OutBus = Data_InBus when blink phase = 0, and 0 when blink phase = 1 (1-cycle registered).
- Each Tick: blink phase toggles and the tick counter increments.
- On the Tick that makes the counter equal HIT_TICKS: -> PLAY next cycle with Freeze = 0. The counter clears.
- Tick counter width is $clog2(HIT_TICKS+1). No wrap beyond HIT_TICKS.

OVER:
- Freeze = 1, GameOver = 1, Data_OutBus = all ones, Lives = 0.
- Start press -> PLAY next cycle with Lives = LIVES and GameOver = 0.

Other rules:
- Lives never decrements below 0, and only decrements on an accepted collision in PLAY.
- Hit is never asserted outside the cycle after an accepted collision.

Test Plan:
1. Assert RESET_InLow = 0 asynchronously while in PLAY with Lives = 2 -> without waiting for a clock edge: Data_OutBus = 0, Freeze = 1, Lives = 3, GameOver = 0, Hit = 0; after release FSM in IDLE.
2. In IDLE, drive Start 1->0 and hold low for 10 cycles, with Data_InBus = 8'h18 -> Freeze = 0 one cycle after the edge. Data_OutBus = 8'h18 one cycle after entering PLAY. No second start event.
3. In PLAY, drive Lost_InLow = 0 with Tick = 0 for 5 cycles -> no Hit, Lives = 3. Then drive Tick = 1 and Lost_InLow = 0 for one cycle -> next cycle Hit = 1 for exactly 1 cycle, Lives = 2, Freeze = 1.
4. In HIT with HIT_TICKS = 4 and Data_InBus = 8'h3C, pulse Tick 4 times -> Data_OutBus sequence 3C, 00, 3C, 00 (changing per Tick). Freeze drops to 0 the cycle after the 4th Tick. Collisions during HIT are not counted.
5. Three accepted collisions from Lives = 3 -> after the third: Lives = 0, GameOver = 1, Data_OutBus = 8'hFF, Freeze = 1. A Start falling edge then gives PLAY, Lives = 3, GameOver = 0.
6. In PLAY, an accepted collision and a Start falling edge in the same cycle -> Hit = 1, Lives decremented, state HIT. The start press has no effect.

Source files
------------

// File: rtl/cc_collision_controller.sv
// Round-level game flow controller: start, play, hit recovery with blink, game over.
// Sits between the player/obstacle comparator and the display/scroll logic; every
// output is driven straight from a register.
module cc_collision_controller #(
  parameter int DATAWIDTH  = 8,
  parameter int LIVES      = 3,
  parameter int LIVESWIDTH = 2,
  parameter int HIT_TICKS  = 4
) (
  input  logic                  CC_COLLISION_CONTROLLER_CLOCK_50,
  input  logic                  CC_COLLISION_CONTROLLER_RESET_InLow,
  input  logic                  CC_COLLISION_CONTROLLER_Start_InLow,
  input  logic                  CC_COLLISION_CONTROLLER_Tick_InHigh,
  input  logic [DATAWIDTH-1:0]  CC_COLLISION_CONTROLLER_Data_InBus,
  input  logic                  CC_COLLISION_CONTROLLER_Lost_InLow,
  output logic [DATAWIDTH-1:0]  CC_COLLISION_CONTROLLER_Data_OutBus,
  output logic                  CC_COLLISION_CONTROLLER_Freeze_OutHigh,
  output logic [LIVESWIDTH-1:0] CC_COLLISION_CONTROLLER_Lives_OutBus,
  output logic                  CC_COLLISION_CONTROLLER_Hit_OutHigh,
  output logic                  CC_COLLISION_CONTROLLER_GameOver_OutHigh
);

  localparam int CW = $clog2(HIT_TICKS + 1);

  typedef enum logic [1:0] {IDLE, PLAY, HIT, OVER} state_t;

  state_t                state, state_nx;
  logic [LIVESWIDTH-1:0] lives, lives_nx;
  logic [DATAWIDTH-1:0]  data_q, data_nx;
  logic                  freeze, freeze_nx;
  logic                  hit, hit_nx;
  logic                  over, over_nx;
  logic [CW-1:0]         cnt, cnt_nx;
  logic                  blink, blink_nx;
  logic                  start_prev;
  logic                  press;
  logic                  collision;

  // A press is the falling edge of the (already synchronised) start level.
  assign press     = start_prev & ~CC_COLLISION_CONTROLLER_Start_InLow;
  // Collisions only count on a frame tick, masking mid-frame comparator glitches.
  assign collision = CC_COLLISION_CONTROLLER_Tick_InHigh & ~CC_COLLISION_CONTROLLER_Lost_InLow;

  // State and registered outputs; reset value of start_prev hides a button held through reset.
  always_ff @(posedge CC_COLLISION_CONTROLLER_CLOCK_50 or negedge CC_COLLISION_CONTROLLER_RESET_InLow) begin
    if (!CC_COLLISION_CONTROLLER_RESET_InLow) begin
      state      <= IDLE;
      lives      <= LIVESWIDTH'(LIVES);
      data_q     <= '0;
      freeze     <= 1'b1;
      hit        <= 1'b0;
      over       <= 1'b0;
      cnt        <= '0;
      blink      <= 1'b0;
      start_prev <= 1'b1;
    end else begin
      state      <= state_nx;
      lives      <= lives_nx;
      data_q     <= data_nx;
      freeze     <= freeze_nx;
      hit        <= hit_nx;
      over       <= over_nx;
      cnt        <= cnt_nx;
      blink      <= blink_nx;
      start_prev <= CC_COLLISION_CONTROLLER_Start_InLow;
    end
  end

  // Next-state and next-output decode; freeze/game-over follow the state being entered.
  always_comb begin
    state_nx = state;
    lives_nx = lives;
    data_nx  = data_q;
    hit_nx   = 1'b0;
    cnt_nx   = cnt;
    blink_nx = blink;
    case (state)
      IDLE: begin
        data_nx = '0;
        if (press) begin
          state_nx = PLAY;
          lives_nx = LIVESWIDTH'(LIVES);
        end
      end
      PLAY: begin
        data_nx  = CC_COLLISION_CONTROLLER_Data_InBus;
        cnt_nx   = '0;
        blink_nx = 1'b0;
        // Start is ignored here, so a simultaneous press never beats a collision.
        if (collision) begin
          hit_nx = 1'b1;
          if (lives <= LIVESWIDTH'(1)) begin
            state_nx = OVER;
            lives_nx = '0;
            data_nx  = '1;
          end else begin
            state_nx = HIT;
            lives_nx = lives - 1'b1;
          end
        end
      end
      HIT: begin
        data_nx = blink ? '0 : CC_COLLISION_CONTROLLER_Data_InBus;
        if (CC_COLLISION_CONTROLLER_Tick_InHigh) begin
          blink_nx = ~blink;
          if (cnt == CW'(HIT_TICKS - 1)) begin
            // Blink is cleared too so an odd HIT_TICKS never leaves it set.
            state_nx = PLAY;
            cnt_nx   = '0;
            blink_nx = 1'b0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      OVER: begin
        data_nx  = '1;
        lives_nx = '0;
        if (press) begin
          state_nx = PLAY;
          lives_nx = LIVESWIDTH'(LIVES);
        end
      end
      default: state_nx = IDLE;
    endcase
    freeze_nx = (state_nx != PLAY);
    over_nx   = (state_nx == OVER);
  end

  assign CC_COLLISION_CONTROLLER_Data_OutBus      = data_q;
  assign CC_COLLISION_CONTROLLER_Freeze_OutHigh   = freeze;
  assign CC_COLLISION_CONTROLLER_Lives_OutBus     = lives;
  assign CC_COLLISION_CONTROLLER_Hit_OutHigh      = hit;
  assign CC_COLLISION_CONTROLLER_GameOver_OutHigh = over;

endmodule

// File: tb/tb_cc_collision_controller.sv
// Self-checking bench for cc_collision_controller: directed scenarios plus a
// randomized run, all compared against a round-level behavioural model.
module tb_cc_collision_controller;

  localparam int DW = 8;
  localparam int NL = 3;
  localparam int LW = 2;
  localparam int HT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b1;
  logic          tick = 1'b0;
  logic [DW-1:0] din = '0;
  logic          lost = 1'b1;
  logic [DW-1:0] dout;
  logic          freeze;
  logic [LW-1:0] lives;
  logic          hit;
  logic          game_over;

  int checks = 0;
  int errors = 0;

  // Model: round phase as an int (0 waiting, 1 playing, 2 recovering, 3 game over)
  int m_phase;
  int m_lives;
  int m_left;      // frame ticks still to spend recovering
  int m_data;
  int m_freeze;
  int m_hit;
  int m_over;
  int m_prev_start;

  cc_collision_controller #(
    .DATAWIDTH(DW), .LIVES(NL), .LIVESWIDTH(LW), .HIT_TICKS(HT)
  ) dut (
    .CC_COLLISION_CONTROLLER_CLOCK_50        (clk),
    .CC_COLLISION_CONTROLLER_RESET_InLow     (rst_n),
    .CC_COLLISION_CONTROLLER_Start_InLow     (start),
    .CC_COLLISION_CONTROLLER_Tick_InHigh     (tick),
    .CC_COLLISION_CONTROLLER_Data_InBus      (din),
    .CC_COLLISION_CONTROLLER_Lost_InLow      (lost),
    .CC_COLLISION_CONTROLLER_Data_OutBus     (dout),
    .CC_COLLISION_CONTROLLER_Freeze_OutHigh  (freeze),
    .CC_COLLISION_CONTROLLER_Lives_OutBus    (lives),
    .CC_COLLISION_CONTROLLER_Hit_OutHigh     (hit),
    .CC_COLLISION_CONTROLLER_GameOver_OutHigh(game_over)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_phase = 0; m_lives = NL; m_left = 0; m_data = 0;
    m_freeze = 1; m_hit = 0; m_over = 0; m_prev_start = 1;
  endtask

  // Advance the model by one clock using the inputs the DUT is about to sample.
  task automatic model_step();
    bit pressed;
    bit crash;
    int done;
    pressed = (m_prev_start == 1) && (start == 1'b0);
    crash   = (tick == 1'b1) && (lost == 1'b0);
    m_hit   = 0;
    case (m_phase)
      0: begin
        m_data = 0;
        if (pressed) begin m_phase = 1; m_lives = NL; end
      end
      1: begin
        m_data = int'(din);
        if (crash) begin
          m_hit = 1;
          if (m_lives == 1) begin
            m_phase = 3; m_lives = 0; m_data = (1 << DW) - 1;
          end else begin
            m_phase = 2; m_lives = m_lives - 1; m_left = HT;
          end
        end
      end
      2: begin
        done   = HT - m_left;
        m_data = (done % 2 == 1) ? 0 : int'(din);
        if (tick) begin
          m_left = m_left - 1;
          if (m_left == 0) m_phase = 1;
        end
      end
      default: begin
        m_data = (1 << DW) - 1; m_lives = 0;
        if (pressed) begin m_phase = 1; m_lives = NL; end
      end
    endcase
    m_freeze     = (m_phase != 1) ? 1 : 0;
    m_over       = (m_phase == 3) ? 1 : 0;
    m_prev_start = int'(start);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Pulse one tick, then let a few frames pass without ticks.
  task automatic tick_then_idle(input int idle);
    tick = 1'b1; step(); tick = 1'b0;
    repeat (idle) step();
  endtask

  task automatic collide();
    tick = 1'b1; lost = 1'b0; step();
    tick = 1'b0; lost = 1'b1;
  endtask

  task automatic press_start();
    start = 1'b1; step();
    start = 1'b0; step();
    start = 1'b1;
  endtask

  task automatic test_reset();
    start = 1'b1; tick = 1'b0; lost = 1'b1; din = 8'h00;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    step();
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", dout); end
    checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL reset_freeze got %b want 1", freeze); end
    checks++; if (lives !== LW'(NL)) begin errors++; $display("FAIL reset_lives got %0d want %0d", lives, NL); end
    checks++; if (hit !== 1'b0 || game_over !== 1'b0) begin errors++; $display("FAIL reset_flags hit %b over %b want 0 0", hit, game_over); end
    // Reach PLAY with two lives, then pull reset mid-cycle.
    din = 8'h5A;
    press_start();
    collide();
    repeat (HT) tick_then_idle(2);
    step();
    checks++; if (lives !== 2'd2 || freeze !== 1'b0) begin errors++; $display("FAIL pre_reset_play lives %0d freeze %b want 2 0", lives, freeze); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (dout !== 8'h00 || freeze !== 1'b1 || lives !== LW'(NL) || game_over !== 1'b0 || hit !== 1'b0)
      begin errors++; $display("FAIL async_reset data %h freeze %b lives %0d over %b hit %b want 00 1 3 0 0", dout, freeze, lives, game_over, hit); end
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    step();
    checks++; if (freeze !== 1'b1 || dout !== 8'h00) begin errors++; $display("FAIL post_reset_idle freeze %b data %h want 1 00", freeze, dout); end
  endtask

  task automatic test_start_press();
    din = 8'h18;
    start = 1'b0; step();
    checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL start_freeze got %b want 0", freeze); end
    step();
    checks++; if (dout !== 8'h18) begin errors++; $display("FAIL start_data got %h want 18", dout); end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++; if (freeze !== 1'(m_freeze) || lives !== LW'(m_lives) || dout !== DW'(m_data))
        begin errors++; $display("FAIL start_hold cyc %0d freeze %b lives %0d data %h want %0d %0d %h", i, freeze, lives, dout, m_freeze, m_lives, m_data); end
    end
    start = 1'b1; step();
  endtask

  task automatic test_glitch_mask();
    lost = 1'b0; tick = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (hit !== 1'b0 || lives !== 2'd3) begin errors++; $display("FAIL glitch_mask cyc %0d hit %b lives %0d want 0 3", i, hit, lives); end
    end
    tick = 1'b1; step();
    tick = 1'b0; lost = 1'b1;
    checks++; if (hit !== 1'b1 || lives !== 2'd2 || freeze !== 1'b1) begin errors++; $display("FAIL accept_hit hit %b lives %0d freeze %b want 1 2 1", hit, lives, freeze); end
    step();
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL hit_pulse_width got %b want 0", hit); end
  endtask

  task automatic test_hit_blink();
    logic [DW-1:0] want;
    din = 8'h3C; lost = 1'b0;
    step(); step();
    checks++; if (dout !== 8'h3C) begin errors++; $display("FAIL blink_pre got %h want 3c", dout); end
    for (int k = 1; k <= HT; k++) begin
      if (k == HT) lost = 1'b1;
      tick = 1'b1; step(); tick = 1'b0;
      if (k == HT) begin
        checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL blink_exit_freeze got %b want 0", freeze); end
      end
      step(); step();
      want = (k % 2 == 1 && k != HT) ? 8'h00 : 8'h3C;
      checks++; if (dout !== want || hit !== 1'b0 || lives !== 2'd2)
        begin errors++; $display("FAIL blink_tick%0d data %h hit %b lives %0d want %h 0 2", k, dout, hit, lives, want); end
    end
  endtask

  task automatic test_game_over();
    // Burn remaining lives, restart, then three collisions from a full count.
    while (m_phase != 3) begin
      collide();
      if (m_phase == 2) repeat (HT) tick_then_idle(1);
    end
    press_start();
    checks++; if (lives !== LW'(NL) || game_over !== 1'b0) begin errors++; $display("FAIL restart1 lives %0d over %b want 3 0", lives, game_over); end
    for (int n = 0; n < 3; n++) begin
      step();
      collide();
      if (n < 2) repeat (HT) tick_then_idle(1);
    end
    checks++; if (lives !== 2'd0 || game_over !== 1'b1 || dout !== 8'hFF || freeze !== 1'b1 || hit !== 1'b1)
      begin errors++; $display("FAIL game_over lives %0d over %b data %h freeze %b hit %b want 0 1 ff 1 1", lives, game_over, dout, freeze, hit); end
    step();
    checks++; if (dout !== 8'hFF || hit !== 1'b0) begin errors++; $display("FAIL over_hold data %h hit %b want ff 0", dout, hit); end
    press_start();
    checks++; if (lives !== LW'(NL) || game_over !== 1'b0 || freeze !== 1'b0) begin errors++; $display("FAIL restart2 lives %0d over %b freeze %b want 3 0 0", lives, game_over, freeze); end
  endtask

  task automatic test_collision_vs_start();
    start = 1'b1; step();
    start = 1'b0; tick = 1'b1; lost = 1'b0; step();
    tick = 1'b0; lost = 1'b1;
    checks++; if (hit !== 1'b1 || lives !== 2'd2 || freeze !== 1'b1 || game_over !== 1'b0)
      begin errors++; $display("FAIL coll_vs_start hit %b lives %0d freeze %b over %b want 1 2 1 0", hit, lives, freeze, game_over); end
    step(); step();
    checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL coll_vs_start_hold freeze %b want 1", freeze); end
    start = 1'b1;
    repeat (HT) tick_then_idle(1);
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
      tick  = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
      lost  = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      din   = DW'($urandom);
      step();
      checks++;
      if (dout !== DW'(m_data) || freeze !== 1'(m_freeze) || lives !== LW'(m_lives) ||
          hit !== 1'(m_hit) || game_over !== 1'(m_over))
        begin
          errors++;
          $display("FAIL random cyc %0d data %h freeze %b lives %0d hit %b over %b want %h %0d %0d %0d %0d",
                   i, dout, freeze, lives, hit, game_over, m_data, m_freeze, m_lives, m_hit, m_over);
        end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start_press();
    test_glitch_mask();
    test_hit_blink();
    test_game_over();
    test_collision_vs_start();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
